// File: rtl/data_memory_be_pkg.sv
// Shared types and defaults for the byte-enabled data memory.
// Holds the FSM encoding and default geometry used by the top, lanes and interface.
package data_memory_be_pkg;

    localparam int DM_DSIZE = 16;
    localparam int DM_ASIZE = 8;
    localparam int DM_BSIZE = 8;

    typedef enum logic [0:0] {
        DM_INIT = 1'b0,
        DM_RUN  = 1'b1
    } dm_state_t;

    function automatic int dm_nlane(input int dsize, input int bsize);
        return dsize / bsize;
    endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response bundle between the load/store stage and the data memory.
// master drives requests and consumes responses; slave is the memory side.
interface data_memory_be_if
    import data_memory_be_pkg::*;
#(
    parameter int DSIZE = DM_DSIZE,
    parameter int ASIZE = DM_ASIZE,
    parameter int BSIZE = DM_BSIZE
);
    localparam int NLANE = dm_nlane(DSIZE, BSIZE);

    logic             req_valid;
    logic             req_ready;
    logic             req_wen;
    logic [ASIZE-1:0] req_addr;
    logic [DSIZE-1:0] req_wdata;
    logic [NLANE-1:0] req_be;
    logic             rsp_valid;
    logic [DSIZE-1:0] rsp_rdata;
    logic             init_busy;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, init_busy
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, init_busy
    );

endinterface

// File: rtl/data_memory_be_dm_ram_lane.sv
// One byte lane of the data memory: synchronous write, registered read port.
// The read register clears on reset; the array itself is never reset.
module dm_ram_lane #(
    parameter int BSIZE = 8,
    parameter int ASIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [ASIZE-1:0] addr,
    input  logic [BSIZE-1:0] wdata,
    output logic [BSIZE-1:0] rdata
);
    localparam int DEPTH = 2 ** ASIZE;

    logic [BSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_be.sv
// Single-port data memory with per-byte write enables and a post-reset clear sweep.
// Reads return one cycle after acceptance; requests are refused while the sweep runs.
module data_memory_be
    import data_memory_be_pkg::*;
#(
    parameter int DSIZE = DM_DSIZE,
    parameter int ASIZE = DM_ASIZE,
    parameter int BSIZE = DM_BSIZE
) (
    input  logic             clk,
    input  logic             rst,
    data_memory_be_if.slave  bus
);
    localparam int NLANE = dm_nlane(DSIZE, BSIZE);
    localparam logic [ASIZE-1:0] LAST_ADDR = '1;

    dm_state_t        state_q;
    dm_state_t        state_d;
    logic [ASIZE-1:0] cnt_q;
    logic [ASIZE-1:0] cnt_d;
    logic             rsp_valid_q;

    logic             accept;
    logic             rd_accept;
    logic [NLANE-1:0] lane_we;
    logic [NLANE-1:0] lane_we_gated;
    logic [ASIZE-1:0] ram_addr;
    logic [DSIZE-1:0] ram_wdata;
    logic [DSIZE-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= DM_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rd_accept;
        end
    end

    // The sweep owns the RAM port in INIT; requests are only looked at in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        rd_accept = 1'b0;
        lane_we   = '0;
        ram_addr  = bus.req_addr;
        ram_wdata = bus.req_wdata;
        case (state_q)
            DM_INIT: begin
                ram_addr  = cnt_q;
                ram_wdata = '0;
                lane_we   = '1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DM_RUN;
                end
            end
            DM_RUN: begin
                accept    = bus.req_valid;
                rd_accept = accept & ~bus.req_wen;
                if (accept && bus.req_wen) begin
                    lane_we = bus.req_be;
                end
            end
            default: begin
                state_d = DM_INIT;
            end
        endcase
    end

    // Reset must leave the array untouched, including on the edge it is first seen.
    assign lane_we_gated = lane_we & {NLANE{rst}};

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        dm_ram_lane #(
            .BSIZE (BSIZE),
            .ASIZE (ASIZE)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we_gated[i]),
            .re    (rd_accept),
            .addr  (ram_addr),
            .wdata (ram_wdata[i*BSIZE +: BSIZE]),
            .rdata (ram_rdata[i*BSIZE +: BSIZE])
        );
    end

    assign bus.req_ready = (state_q == DM_RUN);
    assign bus.init_busy = (state_q == DM_INIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_data_memory_be.sv
// Scoreboard bench for data_memory_be with a 16-word x 16-bit geometry.
// Reads push the model value; a negedge monitor pops and compares each response.
module tb_data_memory_be;

    localparam int DSIZE = 16;
    localparam int ASIZE = 4;
    localparam int BSIZE = 8;
    localparam int DEPTH = 2 ** ASIZE;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [DSIZE-1:0] model [DEPTH];
    logic [DSIZE-1:0] sb [$];

    data_memory_be_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .BSIZE(BSIZE)) bus ();

    data_memory_be #(.DSIZE(DSIZE), .ASIZE(ASIZE), .BSIZE(BSIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rsp_data", {16'h0, bus.rsp_rdata}, {16'h0, sb.pop_front()});
            end
        end
    end

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
    endtask

    task automatic do_write(input int addr, input logic [15:0] data, input logic [1:0] be);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = addr[ASIZE-1:0];
        bus.req_wdata = data;
        bus.req_be    = be;
        if (be[0]) model[addr][7:0]  = data[7:0];
        if (be[1]) model[addr][15:8] = data[15:8];
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_read(input int addr);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = addr[ASIZE-1:0];
        sb.push_back(model[addr]);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("rd_latency", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.init_busy}, 32'd1);
        chk({tag, "_rspv"},  {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rdata"}, {16'h0, bus.rsp_rdata}, 32'd0);
    endtask

    // Releases reset and counts edges until req_ready; optionally pokes requests during INIT.
    task automatic release_and_sweep(input string tag, input bit junk);
        int n;
        n = 0;
        rst = 1'b1;
        if (junk) begin
            bus.req_valid = 1'b1;
            bus.req_wen   = 1'b0;
            bus.req_addr  = 4'd2;
        end
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.req_ready === 1'b1) break;
            chk({tag, "_busy_in_sweep"}, {31'd0, bus.init_busy}, 32'd1);
            if (junk && n == 5) begin
                bus.req_wen   = 1'b1;
                bus.req_wdata = 16'hFFFF;
                bus.req_be    = 2'b11;
            end
        end
        idle_inputs();
        chk({tag, "_sweep_cycles"}, n, DEPTH);
        chk({tag, "_busy_after"}, {31'd0, bus.init_busy}, 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        release_and_sweep("sweep0", 1'b1);
        for (int a = 0; a < DEPTH; a++) do_read(a);

        do_write(3, 16'hBEEF, 2'b11);
        do_read(3);
        do_write(3, 16'h1234, 2'b01);
        do_read(3);
        do_write(3, 16'h5678, 2'b00);
        do_read(3);
        @(posedge clk);
        #1;
        chk("rspv_idle", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rdata_hold", {16'h0, bus.rsp_rdata}, 32'h0000BE34);

        do_write(5, 16'hA5A5, 2'b11);
        do_read(5);
        do_read(3);
        do_read(2);
        do_write(10, 16'h7777, 2'b10);
        do_read(10);

        // Reset lands together with a read request: it must not be accepted.
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 4'd3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        check_reset_outputs("run_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("run_rst2");

        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_init_busy", {31'd0, bus.init_busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("init_rst");

        release_and_sweep("sweep1", 1'b0);
        do_read(3);
        do_read(5);
        do_read(10);
        do_read(15);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
